// File: rtl/result_mon_pkg.sv
// rtl/result_mon_pkg.sv - shared types, constants and helpers for result_monitor
package result_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LANE_W = 8;

  localparam logic [31:0] DEF_DONE_VALUE = 32'h1;

  // Width of an index that can also encode "none" (== n).
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/result_monitor_if.sv
// rtl/result_monitor_if.sv - snooped data-memory store bus
interface result_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]                        d_mem_addr;
  logic [DATA_W-1:0]                        d_mem_wdata;
  logic [DATA_W/result_mon_pkg::LANE_W-1:0] d_mem_wen;

  modport master (output d_mem_addr, output d_mem_wdata, output d_mem_wen);
  modport slave  (input  d_mem_addr, input  d_mem_wdata, input  d_mem_wen);

endinterface

// File: rtl/result_mon_capture.sv
// rtl/result_mon_capture.sv - result word array with byte-lane merge and written bits
module result_mon_capture
  import result_mon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_RESULTS = 6,
  parameter int IDX_W       = idx_w(NUM_RESULTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [DATA_W/LANE_W-1:0] wen,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [IDX_W-1:0]         ridx,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rwritten
);

  localparam int LANES = DATA_W / LANE_W;

  logic [DATA_W-1:0]      words_q [NUM_RESULTS];
  logic [DATA_W-1:0]      words_d [NUM_RESULTS];
  logic [NUM_RESULTS-1:0] written_q;
  logic [NUM_RESULTS-1:0] written_d;

  // Re-arm wipes every word; otherwise merge only the enabled lanes into the addressed word.
  always_comb begin
    words_d   = words_q;
    written_d = written_q;
    if (clr) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        words_d[i] = '0;
      end
      written_d = '0;
    end else if (we) begin
      for (int k = 0; k < LANES; k++) begin
        if (wen[k]) begin
          words_d[widx][k*LANE_W +: LANE_W] = wdata[k*LANE_W +: LANE_W];
        end
      end
      written_d[widx] = 1'b1;
    end
  end

  // Word array and written bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        words_q[i] <= '0;
      end
      written_q <= '0;
    end else begin
      words_q   <= words_d;
      written_q <= written_d;
    end
  end

  assign rdata    = words_q[ridx];
  assign rwritten = written_q[ridx];

endmodule

// File: rtl/result_monitor.sv
// rtl/result_monitor.sv - store snooper and result checker for CPU self-test programs (watchdog: RESULT_MON_TIMEOUT_EN)
module result_monitor
  import result_mon_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_RESULTS = 6,
  parameter logic [ADDR_W-1:0] RESULT_BASE = ADDR_W'(32'h200),
  parameter logic [ADDR_W-1:0] DONE_ADDR   = ADDR_W'(32'h300),
  parameter logic [DATA_W-1:0] DONE_VALUE  = DATA_W'(DEF_DONE_VALUE),
  parameter int                MAX_CYCLES  = 10000,
  parameter int                CNT_W       = 32,
  localparam int               IDX_W       = idx_w(NUM_RESULTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  result_monitor_if.slave               bus,
  input  logic [NUM_RESULTS*DATA_W-1:0] exp_data,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [IDX_W-1:0]              pass_count,
  output logic [IDX_W-1:0]              fail_idx,
  output logic                          timeout,
  output logic [CNT_W-1:0]              cycle_count
);

  localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NUM_RESULTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RESULTS - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);
`ifdef RESULT_MON_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [IDX_W-1:0]  chk_idx_q, chk_idx_d;
  logic [IDX_W-1:0]  pass_count_q, pass_count_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;

  logic [ADDR_W-1:0] cap_word;
  logic              in_window;
  logic              cap_we;
  logic              cap_clr;
  logic              done_hit;
  logic              wd_hit;
  logic [DATA_W-1:0] rd_data;
  logic              rd_written;
  logic              word_match;
  logic [DATA_W-1:0] exp_words [NUM_RESULTS];

  // Decode the snooped store: result-window hit and completion-flag hit.
  always_comb begin
    cap_word  = (bus.d_mem_addr - RESULT_BASE) >> 2;
    in_window = cap_word < ADDR_W'(NUM_RESULTS);
    cap_we    = (state_q == ST_RUN) && (|bus.d_mem_wen) && in_window;
    done_hit  = (bus.d_mem_addr == DONE_ADDR) && (&bus.d_mem_wen) &&
                (bus.d_mem_wdata == DONE_VALUE);
    wd_hit    = WD_EN && (cycle_count_q == WD_LIMIT);
  end

  // Unflatten the expected vector and compare it against the word under check.
  always_comb begin
    for (int i = 0; i < NUM_RESULTS; i++) begin
      exp_words[i] = exp_data[i*DATA_W +: DATA_W];
    end
    word_match = rd_written && (rd_data == exp_words[chk_idx_q]);
  end

  result_mon_capture #(
    .DATA_W      (DATA_W),
    .NUM_RESULTS (NUM_RESULTS),
    .IDX_W       (IDX_W)
  ) u_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cap_clr),
    .we       (cap_we),
    .widx     (cap_word[IDX_W-1:0]),
    .wen      (bus.d_mem_wen),
    .wdata    (bus.d_mem_wdata),
    .ridx     (chk_idx_q),
    .rdata    (rd_data),
    .rwritten (rd_written)
  );

  // Next state, counters and verdict; completion store takes priority over the watchdog.
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    chk_idx_d     = chk_idx_q;
    pass_count_d  = pass_count_q;
    fail_idx_d    = fail_idx_q;
    timeout_d     = timeout_q;
    pass_d        = pass_q;
    cap_clr       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_RUN;
          cycle_count_d = '0;
          chk_idx_d     = '0;
          pass_count_d  = '0;
          fail_idx_d    = IDX_NONE;
          timeout_d     = 1'b0;
          pass_d        = 1'b0;
          cap_clr       = 1'b1;
        end
      end
      ST_RUN: begin
        if (!(&cycle_count_q)) begin
          cycle_count_d = cycle_count_q + 1'b1;
        end
        if (done_hit) begin
          state_d   = ST_CHECK;
          chk_idx_d = '0;
        end else if (wd_hit) begin
          state_d   = ST_CHECK;
          chk_idx_d = '0;
          timeout_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (word_match) begin
          pass_count_d = pass_count_q + 1'b1;
        end else if (fail_idx_q == IDX_NONE) begin
          fail_idx_d = chk_idx_q;
        end
        if (chk_idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          pass_d  = (pass_count_d == IDX_NONE) && !timeout_q;
        end else begin
          chk_idx_d = chk_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      chk_idx_q     <= '0;
      pass_count_q  <= '0;
      fail_idx_q    <= IDX_NONE;
      timeout_q     <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      chk_idx_q     <= chk_idx_d;
      pass_count_q  <= pass_count_d;
      fail_idx_q    <= fail_idx_d;
      timeout_q     <= timeout_d;
      pass_q        <= pass_d;
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign pass_count  = pass_count_q;
  assign fail_idx    = fail_idx_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_result_monitor.sv
// tb/tb_result_monitor.sv - directed self-checking bench for result_monitor (RESULT_MON_TIMEOUT_EN selects watchdog cases)
module tb_result_monitor;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 6;
  localparam int IW = 3;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [NR*DW-1:0] exp_data;
  logic             busy, done, pass, timeout;
  logic [IW-1:0]    pass_count, fail_idx;
  logic [CW-1:0]    cycle_count;
  logic [31:0]      exp_w [NR];

  int n_cmp = 0;
  int n_mis = 0;
  int lat;

  result_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  result_monitor #(.MAX_CYCLES(50)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .exp_data    (exp_data),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .pass_count  (pass_count),
    .fail_idx    (fail_idx),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    bus.d_mem_addr  = a;
    bus.d_mem_wdata = d;
    bus.d_mem_wen   = w;
    tick(1);
    bus.d_mem_wen   = 4'h0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic store_words(input logic [5:0] mask);
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) store(32'h200 + 32'(4 * i), exp_w[i], 4'hF);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick(1);
      n++;
    end
    check_eq("wait_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: got no finish, want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    exp_w[0] = 32'd5;
    exp_w[1] = 32'd10;
    exp_w[2] = 32'd15;
    exp_w[3] = 32'd5;
    exp_w[4] = 32'd42;
    exp_w[5] = 32'hFFFF_FFF9;
    for (int i = 0; i < NR; i++) exp_data[i*DW +: DW] = exp_w[i];
    bus.d_mem_addr  = '0;
    bus.d_mem_wdata = '0;
    bus.d_mem_wen   = '0;

    // reset values
    tick(2);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_pass_count", pass_count, 0);
    check_eq("rst_fail_idx", fail_idx, 6);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_cycle_count", cycle_count, 0);
    rst_n = 1'b1;
    tick(1);

    // correct run with an ignored re-arm and an out-of-window store
    pulse_start;
    check_eq("run_busy", busy, 1);
    check_eq("run_cycle0", cycle_count, 0);
    store_words(6'b000111);
    pulse_start;
    store(32'h220, 32'h99, 4'hF);
    store_words(6'b111000);
    store(32'h300, 32'h1, 4'hF);
    check_eq("chk_busy", busy, 1);
    wait_done(lat);
    check_eq("ok_latency", lat, 6);
    check_eq("ok_pass", pass, 1);
    check_eq("ok_pass_count", pass_count, 6);
    check_eq("ok_fail_idx", fail_idx, 6);
    check_eq("ok_timeout", timeout, 0);
    check_eq("ok_busy", busy, 0);
    check_eq("ok_cycles", cycle_count, 9);
    tick(3);
    check_eq("ok_hold_done", done, 1);
    check_eq("ok_hold_cycles", cycle_count, 9);

    // byte-lane merge into word 4, address low bits ignored
    pulse_start;
    store_words(6'b101111);
    store(32'h210, 32'hDEAD_BEEF, 4'hF);
    store(32'h210, 32'h0000_002A, 4'b0001);
    store(32'h212, 32'h0000_0000, 4'b1110);
    store(32'h300, 32'h1, 4'hF);
    wait_done(lat);
    check_eq("merge_pass", pass, 1);
    check_eq("merge_pass_count", pass_count, 6);

    // mismatch at word 2, word 5 missing; stores and start during CHECK ignored
    pulse_start;
    store_words(6'b011011);
    store(32'h208, 32'h10, 4'hF);
    store(32'h300, 32'h1, 4'hF);
    store(32'h214, 32'hFFFF_FFF9, 4'hF);
    pulse_start;
    wait_done(lat);
    check_eq("mis_pass_count", pass_count, 4);
    check_eq("mis_fail_idx", fail_idx, 2);
    check_eq("mis_pass", pass, 0);

    // wrong flag value and partial-lane flag do not end the run
    pulse_start;
    store_words(6'h3F);
    store(32'h300, 32'h2, 4'hF);
    store(32'h300, 32'h1, 4'b0011);
    tick(8);
    check_eq("flag_busy", busy, 1);
    check_eq("flag_done", done, 0);
    store(32'h300, 32'h1, 4'hF);
    wait_done(lat);
    check_eq("flag_latency", lat, 6);
    check_eq("flag_pass", pass, 1);

`ifdef RESULT_MON_TIMEOUT_EN
    // watchdog expiry with all words correct
    pulse_start;
    store_words(6'h3F);
    wait_done(lat);
    check_eq("wd_latency", lat, 50);
    check_eq("wd_timeout", timeout, 1);
    check_eq("wd_pass", pass, 0);
    check_eq("wd_pass_count", pass_count, 6);
    check_eq("wd_cycles", cycle_count, 50);

    // completion store on the watchdog edge wins
    pulse_start;
    store_words(6'h3F);
    tick(43);
    check_eq("tie_busy", busy, 1);
    store(32'h300, 32'h1, 4'hF);
    wait_done(lat);
    check_eq("tie_latency", lat, 6);
    check_eq("tie_timeout", timeout, 0);
    check_eq("tie_pass", pass, 1);
    check_eq("tie_cycles", cycle_count, 50);
`else
    // no watchdog: run continues well past MAX_CYCLES
    pulse_start;
    tick(60);
    check_eq("nowd_busy", busy, 1);
    check_eq("nowd_done", done, 0);
    check_eq("nowd_timeout", timeout, 0);
    check_eq("nowd_cycles", cycle_count, 60);
    store(32'h300, 32'h1, 4'hF);
    wait_done(lat);
    check_eq("nowd_pass", pass, 0);
    check_eq("nowd_pass_count", pass_count, 0);
    check_eq("nowd_fail_idx", fail_idx, 0);
`endif

    // asynchronous reset mid-run, then re-arm
    pulse_start;
    store_words(6'b000111);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_cycles", cycle_count, 0);
    check_eq("arst_fail_idx", fail_idx, 6);
    check_eq("arst_pass_count", pass_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check_eq("arst_idle", busy, 0);
    pulse_start;
    store_words(6'h3F);
    store(32'h300, 32'h1, 4'hF);
    wait_done(lat);
    check_eq("rearm_pass", pass, 1);
    check_eq("rearm_pass_count", pass_count, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
